stream_merger: RTL and testbench
================================

STREAM_MERGER -- requirements
Module: stream_merger

Interface
REQ-001 SHALL take parameter FIFO_DEPTH, default 4, meaning per-channel buffer entries (power of two, >= 4).
REQ-002 SHALL take widths ADDRESS_WIDTH and ID_WIDTH from defines.vh; no local overrides.
REQ-003 SHALL have port clk, input, 1, clock, all state updated on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have ports in_address_1 / in_id_1 / in_valid_1: inputs, ADDRESS_WIDTH / ID_WIDTH / 1, channel-1 beat.
REQ-006 SHALL have port out_stall_1, output, 1, back-pressure to channel-1 source.
REQ-007 SHALL have ports in_address_2 / in_id_2 / in_valid_2 and out_stall_2, mirroring REQ-005/006 for channel 2.
REQ-008 SHALL have ports out_address / out_id / out_channel / out_valid: outputs, ADDRESS_WIDTH / ID_WIDTH / 1 / 1, merged beat; out_channel 0 = ch1, 1 = ch2.
REQ-009 SHALL have port in_ready, input, 1, downstream accepts merged beat.
REQ-010 SHALL have ports seq_error_1, seq_error_2 and overflow, outputs, 1 each, sticky error flags.

Function
REQ-011 SHALL write a channel beat into that channel's FIFO at every rising edge where in_valid_x=1, regardless of out_stall_x (source sees stall one cycle late).
REQ-012 SHALL drive out_stall_x from a register set to (next-cycle occupancy >= FIFO_DEPTH-1), guaranteeing room for the one in-flight beat.
REQ-013 SHALL, on a write while that FIFO is full, drop the beat, keep contents unchanged and set overflow.
REQ-014 SHALL hold one output register; it loads when out_valid=0 or in_ready=1 (a transfer is out_valid=1 and in_ready=1).
REQ-015 SHALL select the loaded beat from the non-empty FIFOs; only one non-empty, take it.
REQ-016 SHALL, when both are non-empty, grant round-robin: the rr pointer (reset = ch1) selects the winner and toggles to the other channel after each grant.
REQ-017 SHALL clear out_valid on a load edge with both FIFOs empty.
REQ-018 SHALL give latency of one cycle: a beat written at edge E into an empty FIFO with a free output register appears on out_* at E+1.
REQ-019 SHALL allow a write and a read of the same FIFO on the same edge; occupancy unchanged; a full FIFO read+write is not overflow.
REQ-020 SHALL wrap FIFO pointers modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
REQ-021 SHALL keep per-channel expected_id (reset 1); on each accepted write compare in_id_x, set seq_error_x on mismatch, then set expected_id = in_id_x+1 mod 2^ID_WIDTH.
REQ-022 SHALL hold out_* stable while out_valid=1 and in_ready=0.
REQ-023 SHALL NOT check or modify addresses; they pass through unchanged.

Reset
REQ-024 SHALL, on reset assertion, immediately clear: both FIFOs empty, out_valid=0, out_address=0, out_id=0, out_channel=0, out_stall_1/2=0, rr pointer=ch1, expected_id_1/2=1, seq_error_1/2=0, overflow=0.
REQ-025 SHALL ignore in_valid_x while reset is high; reset mid-stream discards all buffered beats with no partial output.
REQ-026 SHALL leave error flags set until reset; only reset clears them.

Verification
REQ-027 SHALL verify single stream: ch1 ids 1,2,3 at addr 4,8,12, in_ready=1, ch2 idle -> out_id 1,2,3, out_channel=0, each one cycle after input, no flags.
REQ-028 SHALL verify contention: both channels valid every cycle, in_ready=1 -> outputs alternate ch1,ch2,ch1,...; out_stall_x asserts when occupancy reaches 3 (depth 4); no overflow.
REQ-029 SHALL verify back-pressure: in_ready=0 for 10 cycles, ch1 streaming with stall honoured one cycle late -> out_stall_1=1, occupancy peaks at 4, overflow=0, out_* held; after release ids emerge in order with no gaps.
REQ-030 SHALL verify overflow: force 5 writes to ch2 ignoring stall, in_ready=0 -> overflow=1, 5th beat dropped, first 4 delivered intact.
REQ-031 SHALL verify sequence check: ch1 ids 1,2,4 -> seq_error_1=1 after third beat, seq_error_2=0; ch1 id wrap 2^ID_WIDTH-1 -> 0 gives no error.
REQ-032 SHALL verify reset mid-operation: both FIFOs half full, assert reset asynchronously between edges -> all REQ-024 values immediately; fresh stream from id 1 then passes cleanly.

Source files
------------

// File: rtl/stream_merger.sv
// Two-channel stream merger: per-channel FIFOs with early stall and id sequence checking,
// arbitrated round-robin into a single registered output beat.

// Widths normally come from defines.vh; these fallbacks apply only when it is not compiled first.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module stream_merger_fifo #(
  parameter int FIFO_DEPTH    = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] in_address,
  input  logic [ID_WIDTH-1:0]      in_id,
  input  logic                     in_valid,
  input  logic                     pop,
  output logic [ADDRESS_WIDTH-1:0] head_address,
  output logic [ID_WIDTH-1:0]      head_id,
  output logic                     empty,
  output logic                     stall,
  output logic                     drop,
  output logic                     seq_error
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRESS_WIDTH-1:0] mem_address [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]      mem_id      [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_next;
  logic [ID_WIDTH-1:0]      expected_id;
  logic                     full;
  logic                     accept;

  // A full FIFO still takes a beat when the head leaves on the same edge.
  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign accept       = in_valid && (!full || pop);
  assign drop         = in_valid && full && !pop;
  assign count_next   = count + CW'(accept) - CW'(pop);
  assign head_address = mem_address[rd_ptr];
  assign head_id      = mem_id[rd_ptr];

  // NOTE: storage has no reset; count alone says what is valid, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_address[wr_ptr] <= in_address;
      mem_id[wr_ptr]      <= in_id;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stall       <= 1'b0;
      expected_id <= ID_WIDTH'(1);
      seq_error   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr      <= wr_ptr + PW'(1);
        expected_id <= in_id + ID_WIDTH'(1);
        if (in_id != expected_id) seq_error <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      // Raised one entry early so the beat already in flight from the source still fits.
      stall <= (count_next >= CW'(FIFO_DEPTH - 1));
    end
  end
endmodule

module stream_merger #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`ADDRESS_WIDTH-1:0] in_address_1,
  input  logic [`ID_WIDTH-1:0]      in_id_1,
  input  logic                      in_valid_1,
  output logic                      out_stall_1,
  input  logic [`ADDRESS_WIDTH-1:0] in_address_2,
  input  logic [`ID_WIDTH-1:0]      in_id_2,
  input  logic                      in_valid_2,
  output logic                      out_stall_2,
  output logic [`ADDRESS_WIDTH-1:0] out_address,
  output logic [`ID_WIDTH-1:0]      out_id,
  output logic                      out_channel,
  output logic                      out_valid,
  input  logic                      in_ready,
  output logic                      seq_error_1,
  output logic                      seq_error_2,
  output logic                      overflow
);
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;

  typedef enum logic {CH1 = 1'b0, CH2 = 1'b1} channel_e;

  logic [AW-1:0] head_address_1;
  logic [AW-1:0] head_address_2;
  logic [IW-1:0] head_id_1;
  logic [IW-1:0] head_id_2;
  logic          empty_1;
  logic          empty_2;
  logic          drop_1;
  logic          drop_2;
  logic          pop_1;
  logic          pop_2;
  logic          load;
  logic          contention;
  logic          grant_valid;
  channel_e      grant;
  channel_e      rr;

  stream_merger_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) fifo_1 (
    .clk          (clk),
    .reset        (reset),
    .in_address   (in_address_1),
    .in_id        (in_id_1),
    .in_valid     (in_valid_1),
    .pop          (pop_1),
    .head_address (head_address_1),
    .head_id      (head_id_1),
    .empty        (empty_1),
    .stall        (out_stall_1),
    .drop         (drop_1),
    .seq_error    (seq_error_1)
  );

  stream_merger_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) fifo_2 (
    .clk          (clk),
    .reset        (reset),
    .in_address   (in_address_2),
    .in_id        (in_id_2),
    .in_valid     (in_valid_2),
    .pop          (pop_2),
    .head_address (head_address_2),
    .head_id      (head_id_2),
    .empty        (empty_2),
    .stall        (out_stall_2),
    .drop         (drop_2),
    .seq_error    (seq_error_2)
  );

  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path can infer a latch.
    load        = !out_valid || in_ready;
    contention  = load && !empty_1 && !empty_2;
    grant       = CH1;
    grant_valid = 1'b0;
    if (load) begin
      if (contention) begin
        grant       = rr;
        grant_valid = 1'b1;
      end else if (!empty_1) begin
        grant       = CH1;
        grant_valid = 1'b1;
      end else if (!empty_2) begin
        grant       = CH2;
        grant_valid = 1'b1;
      end
    end
  end

  assign pop_1 = grant_valid && (grant == CH1);
  assign pop_2 = grant_valid && (grant == CH2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr          <= CH1;
      out_valid   <= 1'b0;
      out_address <= '0;
      out_id      <= '0;
      out_channel <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // The pointer only moves when it actually decided between two contenders.
      if (contention) rr <= (grant == CH1) ? CH2 : CH1;
      if (load) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_address <= (grant == CH2) ? head_address_2 : head_address_1;
          out_id      <= (grant == CH2) ? head_id_2 : head_id_1;
          out_channel <= grant;
        end
      end
      if (drop_1 || drop_2) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_merger.sv
// Directed bench for stream_merger: one task per scenario, each with inline expected values.

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module tb_stream_merger;
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] in_address_1 = '0;
  logic [IW-1:0] in_id_1 = '0;
  logic          in_valid_1 = 1'b0;
  logic          out_stall_1;
  logic [AW-1:0] in_address_2 = '0;
  logic [IW-1:0] in_id_2 = '0;
  logic          in_valid_2 = 1'b0;
  logic          out_stall_2;
  logic [AW-1:0] out_address;
  logic [IW-1:0] out_id;
  logic          out_channel;
  logic          out_valid;
  logic          in_ready = 1'b0;
  logic          seq_error_1;
  logic          seq_error_2;
  logic          overflow;

  int vectors = 0;
  int miscompares = 0;

  stream_merger #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_address_1 (in_address_1),
    .in_id_1      (in_id_1),
    .in_valid_1   (in_valid_1),
    .out_stall_1  (out_stall_1),
    .in_address_2 (in_address_2),
    .in_id_2      (in_id_2),
    .in_valid_2   (in_valid_2),
    .out_stall_2  (out_stall_2),
    .out_address  (out_address),
    .out_id       (out_id),
    .out_channel  (out_channel),
    .out_valid    (out_valid),
    .in_ready     (in_ready),
    .seq_error_1  (seq_error_1),
    .seq_error_2  (seq_error_2),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input bit ch2, input int n);
    return ch2 ? AW'(256 + 4 * n) : AW'(4 * n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_1 = 1'b0; in_id_1 = '0; in_address_1 = '0;
    in_valid_2 = 1'b0; in_id_2 = '0; in_address_2 = '0;
    in_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    in_valid_1 = 1'b1; in_id_1 = IW'(1); in_address_1 = addr_of(0, 1);
    in_valid_2 = 1'b1; in_id_2 = IW'(7); in_address_2 = addr_of(1, 1);
    in_ready = 1'b1;
    step();
    step();
    vectors++;
    if ({out_valid, out_channel, out_stall_1, out_stall_2, seq_error_1, seq_error_2, overflow} !== 7'b0 ||
        out_address !== '0 || out_id !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got v=%b ch=%b st=%b%b se=%b%b ov=%b addr=%0h id=%0d, want all zero",
               out_valid, out_channel, out_stall_1, out_stall_2, seq_error_1, seq_error_2, overflow, out_address, out_id);
    end
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ignores_valid: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_single_stream();
    apply_reset();
    in_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        in_valid_1 = 1'b1; in_id_1 = IW'(k + 1); in_address_1 = addr_of(0, k + 1);
      end else begin
        in_valid_1 = 1'b0;
      end
      step();
      vectors++;
      if (k == 0) begin
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL single_latency: got out_valid=%b the edge of the write, want 0", out_valid);
        end
      end else if ({out_valid, out_channel, out_id, out_address} !== {1'b1, 1'b0, IW'(k), addr_of(0, k)}) begin
        miscompares++;
        $display("FAIL single_beat%0d: got v=%b ch=%b id=%0d addr=%0h, want v=1 ch=0 id=%0d addr=%0h",
                 k, out_valid, out_channel, out_id, out_address, k, addr_of(0, k));
      end
    end
    step();
    vectors++;
    if ({out_valid, seq_error_1, seq_error_2, overflow, out_stall_1} !== 5'b0) begin
      miscompares++;
      $display("FAIL single_idle: got v=%b se=%b%b ov=%b st=%b, want all 0",
               out_valid, seq_error_1, seq_error_2, overflow, out_stall_1);
    end
  endtask

  task automatic test_contention();
    int n1, n2, e1, e2;
    logic late1, late2, exp_ch;
    apply_reset();
    n1 = 1; n2 = 1; e1 = 1; e2 = 1;
    late1 = 1'b0; late2 = 1'b0; exp_ch = 1'b0;
    in_ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      // Sources react to stall one cycle late.
      in_valid_1 = (c <= 20) && !late1; in_id_1 = IW'(n1); in_address_1 = addr_of(0, n1);
      in_valid_2 = (c <= 20) && !late2; in_id_2 = IW'(n2); in_address_2 = addr_of(1, n2);
      late1 = out_stall_1;
      late2 = out_stall_2;
      step();
      if (in_valid_1) n1++;
      if (in_valid_2) n2++;
      if (c == 3 || c == 4) begin
        vectors++;
        if ({out_stall_1, out_stall_2} !== ((c == 4) ? 2'b01 : 2'b00)) begin
          miscompares++;
          $display("FAIL contention_stall_c%0d: got stall1=%b stall2=%b, want stall2=%0d only at c4",
                   c, out_stall_1, out_stall_2, (c == 4));
        end
      end
      if (out_valid === 1'b1) begin
        if (c <= 20) begin
          vectors++;
          if (out_channel !== exp_ch) begin
            miscompares++;
            $display("FAIL contention_rr_c%0d: got channel=%b, want %b", c, out_channel, exp_ch);
          end
          exp_ch = ~exp_ch;
        end
        vectors++;
        if (out_channel == 1'b0) begin
          if (out_id !== IW'(e1) || out_address !== addr_of(0, e1)) begin
            miscompares++;
            $display("FAIL contention_ch1_c%0d: got id=%0d addr=%0h, want id=%0d addr=%0h",
                     c, out_id, out_address, IW'(e1), addr_of(0, e1));
          end
          e1++;
        end else begin
          if (out_id !== IW'(e2) || out_address !== addr_of(1, e2)) begin
            miscompares++;
            $display("FAIL contention_ch2_c%0d: got id=%0d addr=%0h, want id=%0d addr=%0h",
                     c, out_id, out_address, IW'(e2), addr_of(1, e2));
          end
          e2++;
        end
      end
    end
    vectors++;
    if (e1 != n1 || e2 != n2 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL contention_drain: delivered %0d/%0d of %0d/%0d, overflow=%b out_valid=%b, want all, 0, 0",
               e1 - 1, e2 - 1, n1 - 1, n2 - 1, overflow, out_valid);
    end
  endtask

  task automatic test_back_pressure();
    int n1, e1;
    logic late1, prev_valid, prev_ready;
    apply_reset();
    n1 = 1; e1 = 1; late1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      in_ready = (c >= 13);
      in_valid_1 = (c <= 26) && !late1; in_id_1 = IW'(n1); in_address_1 = addr_of(0, n1);
      late1 = out_stall_1;
      prev_valid = out_valid;
      prev_ready = in_ready;
      step();
      if (in_valid_1) n1++;
      if (c >= 3 && c <= 12) begin
        vectors++;
        if ({out_valid, out_channel, out_id, out_address} !== {1'b1, 1'b0, IW'(1), addr_of(0, 1)}) begin
          miscompares++;
          $display("FAIL bp_hold_c%0d: got v=%b ch=%b id=%0d addr=%0h, want held id=1 addr=%0h",
                   c, out_valid, out_channel, out_id, out_address, addr_of(0, 1));
        end
      end
      if (c == 12) begin
        vectors++;
        if (out_stall_1 !== 1'b1 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_stall: got stall1=%b overflow=%b, want 1 0", out_stall_1, overflow);
        end
      end
      if (out_valid === 1'b1 && (!prev_valid || prev_ready)) begin
        vectors++;
        if (out_channel !== 1'b0 || out_id !== IW'(e1) || out_address !== addr_of(0, e1)) begin
          miscompares++;
          $display("FAIL bp_order_c%0d: got ch=%b id=%0d addr=%0h, want ch=0 id=%0d addr=%0h",
                   c, out_channel, out_id, out_address, IW'(e1), addr_of(0, e1));
        end
        e1++;
      end
    end
    vectors++;
    if (e1 != n1 || overflow !== 1'b0 || out_valid !== 1'b0 || seq_error_1 !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: delivered %0d of %0d, overflow=%b out_valid=%b seq_error_1=%b, want all, 0, 0, 0",
               e1 - 1, n1 - 1, overflow, out_valid, seq_error_1);
    end
  endtask

  // Occupies the output register with a ch1 beat, then fills ch2 with nwrites beats under in_ready=0.
  task automatic fill_ch2(input int nwrites);
    apply_reset();
    in_valid_1 = 1'b1; in_id_1 = IW'(1); in_address_1 = addr_of(0, 1);
    step();
    in_valid_1 = 1'b0;
    for (int k = 1; k <= nwrites; k++) begin
      in_valid_2 = 1'b1; in_id_2 = IW'(k); in_address_2 = addr_of(1, k);
      step();
    end
  endtask

  task automatic test_full_read_write();
    fill_ch2(4);
    in_ready = 1'b1;
    in_valid_2 = 1'b1; in_id_2 = IW'(5); in_address_2 = addr_of(1, 5);
    step();
    in_valid_2 = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || {out_valid, out_channel, out_id} !== {1'b1, 1'b1, IW'(1)}) begin
      miscompares++;
      $display("FAIL full_rw_edge: got overflow=%b v=%b ch=%b id=%0d, want 0 1 1 1",
               overflow, out_valid, out_channel, out_id);
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      vectors++;
      if ({out_valid, out_channel, out_id, out_address} !== {1'b1, 1'b1, IW'(k), addr_of(1, k)}) begin
        miscompares++;
        $display("FAIL full_rw_beat%0d: got v=%b ch=%b id=%0d addr=%0h, want ch=1 id=%0d addr=%0h",
                 k, out_valid, out_channel, out_id, out_address, k, addr_of(1, k));
      end
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || seq_error_2 !== 1'b0) begin
      miscompares++;
      $display("FAIL full_rw_end: got out_valid=%b overflow=%b seq_error_2=%b, want 0 0 0",
               out_valid, overflow, seq_error_2);
    end
  endtask

  task automatic test_overflow();
    fill_ch2(4);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_at_full: got overflow=%b with 4 entries, want 0", overflow);
    end
    in_valid_2 = 1'b1; in_id_2 = IW'(5); in_address_2 = addr_of(1, 5);
    step();
    in_valid_2 = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || {out_valid, out_channel, out_id} !== {1'b1, 1'b0, IW'(1)}) begin
      miscompares++;
      $display("FAIL ovf_fifth: got overflow=%b v=%b ch=%b id=%0d, want 1 with ch1 id=1 held",
               overflow, out_valid, out_channel, out_id);
    end
    in_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if ({out_valid, out_channel, out_id, out_address} !== {1'b1, 1'b1, IW'(k), addr_of(1, k)}) begin
        miscompares++;
        $display("FAIL ovf_beat%0d: got v=%b ch=%b id=%0d addr=%0h, want ch=1 id=%0d addr=%0h",
                 k, out_valid, out_channel, out_id, out_address, k, addr_of(1, k));
      end
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || overflow !== 1'b1 || seq_error_2 !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_end: got out_valid=%b overflow=%b seq_error_2=%b, want 0 1 0",
               out_valid, overflow, seq_error_2);
    end
  endtask

  task automatic test_sequence();
    logic [IW-1:0] ids [4];
    ids[0] = IW'(1); ids[1] = IW'(2); ids[2] = IW'(4); ids[3] = IW'(5);
    apply_reset();
    in_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid_1 = 1'b1; in_id_1 = ids[k]; in_address_1 = addr_of(0, k + 1);
      step();
      if (k >= 1) begin
        vectors++;
        if ({seq_error_1, seq_error_2} !== ((k >= 2) ? 2'b10 : 2'b00)) begin
          miscompares++;
          $display("FAIL seq_beat%0d: got seq_error_1=%b seq_error_2=%b, want %0d 0",
                   k + 1, seq_error_1, seq_error_2, (k >= 2));
        end
      end
    end
    in_valid_1 = 1'b0;
    step();
    step();
    vectors++;
    if (seq_error_1 !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_sticky: got seq_error_1=%b, want 1", seq_error_1);
    end

    apply_reset();
    in_ready = 1'b1;
    for (int k = 1; k <= (1 << IW) + 1; k++) begin
      in_valid_1 = 1'b1; in_id_1 = IW'(k); in_address_1 = addr_of(0, k);
      step();
    end
    in_valid_1 = 1'b0;
    vectors++;
    if (seq_error_1 !== 1'b0 || out_valid !== 1'b1 || out_id !== IW'(0)) begin
      miscompares++;
      $display("FAIL seq_wrap: got seq_error_1=%b v=%b id=%0d, want 0 1 0", seq_error_1, out_valid, out_id);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 1; k <= 3; k++) begin
      in_valid_1 = 1'b1; in_id_1 = IW'((k == 1) ? 1 : k + 1); in_address_1 = addr_of(0, k);
      in_valid_2 = 1'b1; in_id_2 = IW'(k); in_address_2 = addr_of(1, k);
      step();
    end
    vectors++;
    if ({out_valid, seq_error_1, out_stall_2} !== 3'b111) begin
      miscompares++;
      $display("FAIL mid_before: got v=%b seq_error_1=%b stall2=%b, want 1 1 1", out_valid, seq_error_1, out_stall_2);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, out_channel, out_stall_1, out_stall_2, seq_error_1, seq_error_2, overflow} !== 7'b0 ||
        out_address !== '0 || out_id !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_values: got v=%b ch=%b st=%b%b se=%b%b ov=%b addr=%0h id=%0d, want all zero",
               out_valid, out_channel, out_stall_1, out_stall_2, seq_error_1, seq_error_2, overflow, out_address, out_id);
    end
    step();
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    reset = 1'b0;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_stall_2 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_no_residue: got out_valid=%b stall2=%b, want 0 0", out_valid, out_stall_2);
    end
    in_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k <= 3) begin
        in_valid_1 = 1'b1; in_id_1 = IW'(k); in_address_1 = addr_of(0, k);
      end else begin
        in_valid_1 = 1'b0;
      end
      step();
      if (k >= 2) begin
        vectors++;
        if ({out_valid, out_channel, out_id, out_address} !== {1'b1, 1'b0, IW'(k - 1), addr_of(0, k - 1)}) begin
          miscompares++;
          $display("FAIL mid_fresh%0d: got v=%b ch=%b id=%0d addr=%0h, want ch=0 id=%0d addr=%0h",
                   k - 1, out_valid, out_channel, out_id, out_address, k - 1, addr_of(0, k - 1));
        end
      end
    end
    vectors++;
    if ({seq_error_1, seq_error_2, overflow} !== 3'b0) begin
      miscompares++;
      $display("FAIL mid_flags: got se=%b%b ov=%b, want 000", seq_error_1, seq_error_2, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_contention();
    test_back_pressure();
    test_full_read_write();
    test_overflow();
    test_sequence();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
